// File: rtl/sdram_req_arbiter_if.sv
// rtl/sdram_req_arbiter_if.sv - requester/core bundle shared by the SDRAM request arbiter
// slave modport is the arbiter view; master is the requester plus core side.
interface sdram_req_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE = DATA_WIDTH / 8;

  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data;
  logic [NUM_REQ*BE-1:0]         req_wr;
  logic [NUM_REQ-1:0]            req_rd;
  logic [NUM_REQ-1:0]            req_accept;
  logic [NUM_REQ-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]         req_read_data;
  logic [ADDR_WIDTH-1:0]         core_addr;
  logic [DATA_WIDTH-1:0]         core_write_data;
  logic [BE-1:0]                 core_wr;
  logic                          core_rd;
  logic                          core_accept;
  logic                          core_ack;
  logic [DATA_WIDTH-1:0]         core_read_data;
  logic                          err_tag;

  modport slave (
    input  req_addr, req_write_data, req_wr, req_rd,
    input  core_accept, core_ack, core_read_data,
    output req_accept, req_ack, req_read_data,
    output core_addr, core_write_data, core_wr, core_rd, err_tag
  );

  modport master (
    output req_addr, req_write_data, req_wr, req_rd,
    output core_accept, core_ack, core_read_data,
    input  req_accept, req_ack, req_read_data,
    input  core_addr, core_write_data, core_wr, core_rd, err_tag
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// rtl/sdram_req_arbiter.sv - round-robin arbiter onto one sdram_core port with read tag FIFO
// Granted requester is held until the core accepts; read owners are queued so acks route back.
module sdram_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_req_arbiter_if.slave   bus
);
  localparam int BE = DATA_WIDTH / 8;
  localparam int TW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {ST_ARB, ST_HOLD} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_grant;
  logic [TW-1:0]   r_last;
  logic [TW-1:0]   r_tag_mem [TAG_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic            r_err_tag;

  logic [NUM_REQ-1:0]    w_pending;
  logic [TW-1:0]         w_next_grant;
  logic                  w_any_pending;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [BE-1:0]         w_sel_wr;
  logic                  w_sel_rd;
  logic                  w_wr_any;
  logic                  w_hold;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_rd_go;
  logic                  w_wr_go;
  logic                  w_accept;
  logic                  w_push;
  logic [TW-1:0]         w_head;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pending[i] = bus.req_rd[i] | (|bus.req_wr[i*BE +: BE]);
    end
  end

  // Walk from farthest to nearest so the first pending after r_last wins.
  always_comb begin
    int v_idx;
    v_idx         = 0;
    w_next_grant  = r_last;
    w_any_pending = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = (int'(r_last) + k) % NUM_REQ;
      if (w_pending[v_idx]) begin
        w_next_grant  = TW'(v_idx);
        w_any_pending = 1'b1;
      end
    end
  end

  assign w_sel_addr  = bus.req_addr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = bus.req_write_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_wr    = bus.req_wr[r_grant*BE +: BE];
  assign w_sel_rd    = bus.req_rd[r_grant];
  assign w_wr_any    = |w_sel_wr;
  assign w_hold      = (r_state == ST_HOLD);

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = bus.core_ack & ~w_empty;
  assign w_head  = r_tag_mem[r_rptr[AW-1:0]];

  // A pop in the same cycle frees the slot a full FIFO would otherwise deny.
  assign w_wr_go  = w_hold & w_wr_any;
  assign w_rd_go  = w_hold & ~w_wr_any & w_sel_rd & (~w_full | w_pop);
  assign w_accept = (w_wr_go | w_rd_go) & bus.core_accept;
  assign w_push   = w_rd_go & bus.core_accept;

  assign bus.core_addr       = w_hold  ? w_sel_addr  : '0;
  assign bus.core_write_data = w_hold  ? w_sel_wdata : '0;
  assign bus.core_wr         = w_wr_go ? w_sel_wr    : '0;
  assign bus.core_rd         = w_rd_go;
  assign bus.req_read_data   = bus.core_read_data;
  assign bus.err_tag         = r_err_tag;

  always_comb begin
    bus.req_accept = '0;
    bus.req_ack    = '0;
    if (w_accept) bus.req_accept[r_grant] = 1'b1;
    if (w_pop)    bus.req_ack[w_head]     = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_ARB;
      r_grant   <= '0;
      r_last    <= TW'(NUM_REQ - 1);
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_err_tag <= 1'b0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_any_pending) begin
            r_grant <= w_next_grant;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            r_last  <= r_grant;
            r_state <= ST_ARB;
          end
        end
        default: r_state <= ST_ARB;
      endcase
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (bus.core_ack && w_empty) r_err_tag <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid pointer pair.
  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wptr[AW-1:0]] <= r_grant;
  end
endmodule
